// File: rtl/window_pkg.sv
// Shared encodings for the window button FSM and the window motor driver.
// The state codes are fixed so benches on both sides can decode them.
package window_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_DEAD    = 3'd4,
    ST_FAULT   = 3'd5
  } win_state_t;

  localparam logic DIR_OPEN  = 1'b1;
  localparam logic DIR_CLOSE = 1'b0;

  // Two command pulses in the same cycle cancel each other out.
  function automatic logic cmd_only(input logic this_cmd, input logic other_cmd);
    return this_cmd & ~other_cmd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both stages are cleared by the synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic stage1;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/window_motor_drv.sv
// Window motor H-bridge driver: runs the motor to a limit switch on command,
// inserts a dead time on reversal and latches a fault on timeout or bad sensors.
//
// state   | meaning
// CLOSED  | idle at closed limit, waits for open command
// OPENING | motor_cw on, waits for open limit
// OPEN    | idle at open limit, waits for close command
// CLOSING | motor_ccw on, waits for closed limit
// DEAD    | both enables off before reversing to dir
// FAULT   | both enables off, sticky until reset
module window_motor_drv
  import window_pkg::*;
#(
  parameter int TRAVEL_TIMEOUT = 1000,
  parameter int DEAD_TIME      = 16,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic n_reset,
  input  logic open_cw,
  input  logic close_ccw,
  input  logic lim_open,
  input  logic lim_closed,
  output logic motor_cw,
  output logic motor_ccw,
  output logic busy,
  output logic is_open,
  output logic is_closed,
  output logic fault
);

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_TIME - 1);

  logic             lim_open_s;
  logic             lim_closed_s;
  win_state_t       state;
  win_state_t       state_nxt;
  logic             dir;
  logic             dir_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cmd_open;
  logic             cmd_close;

  sync_2ff u_sync_open (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (lim_open),
    .q       (lim_open_s)
  );

  sync_2ff u_sync_closed (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (lim_closed),
    .q       (lim_closed_s)
  );

  assign cmd_open  = cmd_only(open_cw, close_ccw);
  assign cmd_close = cmd_only(close_ccw, open_cw);

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    if (state != ST_FAULT && lim_open_s && lim_closed_s) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_CLOSED: begin
          if (cmd_open) begin
            state_nxt = ST_OPENING;
            cnt_nxt   = '0;
          end
        end
        ST_OPEN: begin
          if (cmd_close) begin
            state_nxt = ST_CLOSING;
            cnt_nxt   = '0;
          end
        end
        // Limit beats command beats timeout.
        ST_OPENING: begin
          if (lim_open_s) begin
            state_nxt = ST_OPEN;
            cnt_nxt   = '0;
          end else if (cmd_close) begin
            state_nxt = ST_DEAD;
            dir_nxt   = DIR_CLOSE;
            cnt_nxt   = '0;
          end else if (cnt == TRAVEL_LAST) begin
            state_nxt = ST_FAULT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_CLOSING: begin
          if (lim_closed_s) begin
            state_nxt = ST_CLOSED;
            cnt_nxt   = '0;
          end else if (cmd_open) begin
            state_nxt = ST_DEAD;
            dir_nxt   = DIR_OPEN;
            cnt_nxt   = '0;
          end else if (cnt == TRAVEL_LAST) begin
            state_nxt = ST_FAULT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          if (cnt == DEAD_LAST) begin
            state_nxt = (dir == DIR_OPEN) ? ST_OPENING : ST_CLOSING;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_FAULT;
      endcase
    end
  end

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= ST_CLOSED;
      dir       <= DIR_CLOSE;
      cnt       <= '0;
      motor_cw  <= 1'b0;
      motor_ccw <= 1'b0;
      busy      <= 1'b0;
      is_open   <= 1'b0;
      is_closed <= 1'b1;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      cnt       <= cnt_nxt;
      motor_cw  <= (state_nxt == ST_OPENING);
      motor_ccw <= (state_nxt == ST_CLOSING);
      busy      <= (state_nxt == ST_OPENING) || (state_nxt == ST_CLOSING) ||
                   (state_nxt == ST_DEAD);
      is_open   <= (state_nxt == ST_OPEN);
      is_closed <= (state_nxt == ST_CLOSED);
      fault     <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_window_motor_drv.sv
// Directed scenarios plus random traffic against a behavioural window model.
module tb_window_motor_drv;

  localparam int TT = 20;
  localparam int DT = 4;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic open_cw = 1'b0;
  logic close_ccw = 1'b0;
  logic lim_open = 1'b0;
  logic lim_closed = 1'b0;
  logic motor_cw, motor_ccw, busy, is_open, is_closed, fault;

  window_motor_drv #(.TRAVEL_TIMEOUT(TT), .DEAD_TIME(DT), .CNT_W(8)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .open_cw    (open_cw),
    .close_ccw  (close_ccw),
    .lim_open   (lim_open),
    .lim_closed (lim_closed),
    .motor_cw   (motor_cw),
    .motor_ccw  (motor_ccw),
    .busy       (busy),
    .is_open    (is_open),
    .is_closed  (is_closed),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int run_cw = 0;
  int run_ccw = 0;

  // Model: where the window rests (-1 closed, +1 open), which way it moves,
  // how long the motor has run, and how much pause remains before reversing.
  bit m_fault;
  int m_rest;
  int m_move;
  int m_ran;
  int m_pause;
  int m_after;
  bit lo_q[$];
  bit lc_q[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit co, input bit cc, input bit lo, input bit lc, input bit rb);
    bit lo_s, lc_s, want_open, want_close;
    if (!rb) begin
      m_fault = 0; m_rest = -1; m_move = 0; m_ran = 0; m_pause = 0; m_after = 0;
      lo_q = '{0, 0};
      lc_q = '{0, 0};
      return;
    end
    // Decisions see the raw limit level from two edges earlier.
    lo_s = lo_q[0];
    lc_s = lc_q[0];
    lo_q.push_back(lo); void'(lo_q.pop_front());
    lc_q.push_back(lc); void'(lc_q.pop_front());
    want_open  = co && !cc;
    want_close = cc && !co;
    if (m_fault) begin
    end else if (lo_s && lc_s) begin
      m_fault = 1;
    end else if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin m_move = m_after; m_ran = 0; end
    end else if (m_move != 0) begin
      if ((m_move > 0 && lo_s) || (m_move < 0 && lc_s)) begin
        m_rest = m_move; m_move = 0;
      end else if ((m_move > 0 && want_close) || (m_move < 0 && want_open)) begin
        m_after = -m_move; m_move = 0; m_pause = DT;
      end else if (m_ran + 1 >= TT) begin
        m_fault = 1;
      end else begin
        m_ran++;
      end
    end else if (m_rest < 0 && want_open) begin
      m_move = 1; m_ran = 0;
    end else if (m_rest > 0 && want_close) begin
      m_move = -1; m_ran = 0;
    end
  endtask

  task automatic check_all();
    bit moving, idle;
    moving = !m_fault && m_pause == 0 && m_move != 0;
    idle   = !m_fault && m_pause == 0 && m_move == 0;
    chk("motor_cw", motor_cw, moving && m_move > 0);
    chk("motor_ccw", motor_ccw, moving && m_move < 0);
    chk("busy", busy, !m_fault && (m_move != 0 || m_pause > 0));
    chk("is_open", is_open, idle && m_rest > 0);
    chk("is_closed", is_closed, idle && m_rest < 0);
    chk("fault", fault, m_fault);
    chk("exclusive", !(motor_cw && motor_ccw), 1'b1);
  endtask

  task automatic cyc(input bit co, input bit cc, input bit lo, input bit lc, input bit rb);
    open_cw = co; close_ccw = cc; lim_open = lo; lim_closed = lc; n_reset = rb;
    @(posedge clk);
    model_step(co, cc, lo, lc, rb);
    @(negedge clk);
    check_all();
    run_cw  += int'(motor_cw);
    run_ccw += int'(motor_ccw);
  endtask

  initial begin
    int dead_cnt;
    bit r_lo, r_lc;

    // Reset state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_is_closed", is_closed, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_motors", motor_cw | motor_ccw, 1'b0);

    // Normal open: motor runs through the limit synchronizer latency
    repeat (8) cyc(0, 0, 0, 0, 1);
    run_cw = 0;
    cyc(1, 0, 0, 0, 1);
    repeat (8) cyc(0, 0, 0, 0, 1);
    repeat (6) cyc(0, 0, 1, 0, 1);
    chk_int("open_run_len", run_cw, 11);
    chk("open_is_open", is_open, 1'b1);

    // Timeout from OPEN, then commands ignored until reset
    run_ccw = 0;
    cyc(0, 1, 0, 0, 1);
    repeat (30) cyc(0, 0, 0, 0, 1);
    chk_int("timeout_run_len", run_ccw, TT);
    chk("timeout_fault", fault, 1'b1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("fault_sticky", fault, 1'b1);
    cyc(0, 0, 0, 0, 0);
    chk("fault_cleared", is_closed, 1'b1);

    // Reversal during opening
    cyc(1, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    dead_cnt = (!motor_cw && !motor_ccw) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 1);
      if (motor_ccw) break;
      dead_cnt++;
    end
    chk_int("dead_time_len", dead_cnt, DT);
    chk("reverse_ccw", motor_ccw, 1'b1);
    repeat (5) cyc(0, 0, 0, 1, 1);
    chk("reverse_closed", is_closed, 1'b1);
    cyc(0, 0, 0, 0, 1);

    // Simultaneous commands cancel
    repeat (3) cyc(1, 1, 0, 0, 1);
    chk("both_cmd_closed", is_closed, 1'b1);
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(1, 1, 0, 0, 1);
    chk("both_cmd_opening", motor_cw, 1'b1);
    repeat (4) cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Sensor fault: both limits, fault three edges later
    cyc(0, 0, 1, 1, 1);
    chk("sensor_edge1", fault, 1'b0);
    cyc(0, 0, 1, 1, 1);
    chk("sensor_edge2", fault, 1'b0);
    cyc(0, 0, 1, 1, 1);
    chk("sensor_edge3", fault, 1'b1);
    chk("sensor_motors", motor_cw | motor_ccw, 1'b0);
    cyc(0, 0, 0, 0, 0);

    // Limit arriving on the same edge as the timeout wins
    cyc(1, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 1, 0, 1);
    chk("lvt_open", is_open, 1'b1);
    run_ccw = 0;
    cyc(0, 1, 0, 0, 1);
    repeat (17) cyc(0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 1, 1);
    chk_int("lvt_run_len", run_ccw, TT);
    chk("lvt_closed", is_closed, 1'b1);
    chk("lvt_no_fault", fault, 1'b0);

    // Random traffic
    r_lo = 0; r_lc = 0;
    for (int i = 0; i < 3000; i++) begin
      bit co, cc, rb;
      if ($urandom_range(29) == 0) r_lo = !r_lo;
      if ($urandom_range(29) == 0) r_lc = !r_lc;
      if (r_lo && r_lc && $urandom_range(3) != 0) begin
        if ($urandom_range(1) == 0) r_lo = 0; else r_lc = 0;
      end
      co = ($urandom_range(9) == 0);
      cc = ($urandom_range(9) == 0);
      rb = ($urandom_range(199) != 0);
      cyc(co, cc, r_lo, r_lc, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
